// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Op codes, FSM encodings and op-class helpers for the HI/LO MDU.
// Revision : 1.0
// ============================================================================
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic op_is_iter(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_hilo_unit_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo_unit_sign_fix
// Brief    : Operand abs-in at issue, sign restore and divide special cases at
//            result write-back. Purely combinational.
// Revision : 1.0
// ============================================================================
module mdu_hilo_unit_sign_fix #(
  parameter int WIDTH = 32
) (
  // issue side
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic               o_sign_a,
  output logic               o_sign_b,
  // write-back side
  input  logic               i_is_div,
  input  logic               i_sign_a,
  input  logic               i_sign_b,
  input  logic               i_div_zero,
  input  logic               i_div_ovf,
  input  logic [2*WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Signs are only meaningful for signed ops, so unsigned ops report zero.
  assign o_sign_a = i_signed & i_a[WIDTH-1];
  assign o_sign_b = i_signed & i_b[WIDTH-1];
  assign o_mag_a  = o_sign_a ? (~i_a + 1'b1) : i_a;
  assign o_mag_b  = o_sign_b ? (~i_b + 1'b1) : i_b;

  assign w_prod = (i_sign_a ^ i_sign_b) ? (~i_acc + 1'b1) : i_acc;
  assign w_quot = (i_sign_a ^ i_sign_b) ? (~i_acc[WIDTH-1:0] + 1'b1) : i_acc[WIDTH-1:0];
  assign w_rem  = i_sign_a ? (~i_acc[2*WIDTH-1:WIDTH] + 1'b1) : i_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (i_is_div) begin
      // The remainder of a divide-by-zero equals the dividend, so hi = a falls out.
      o_hi = w_rem;
      o_lo = w_quot;
      if (i_div_zero) begin
        o_lo = {WIDTH{1'b1}};
      end else if (i_div_ovf) begin
        o_hi = '0;
        o_lo = C_MOST_NEG;
      end
    end
  end

endmodule : mdu_hilo_unit_sign_fix
`default_nettype wire

// File: rtl/mdu_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo_unit
// Brief    : Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Revision : 1.0
// ============================================================================
module mdu_hilo_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_zero;
  logic               r_ovf;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic               w_ovf;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_next;

  mdu_hilo_unit_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .i_a        (a),
    .i_b        (b),
    .i_signed   (op_is_signed(op)),
    .o_mag_a    (w_mag_a),
    .o_mag_b    (w_mag_b),
    .o_sign_a   (w_sign_a),
    .o_sign_b   (w_sign_b),
    .i_is_div   (r_is_div),
    .i_sign_a   (r_sign_a),
    .i_sign_b   (r_sign_b),
    .i_div_zero (r_zero),
    .i_div_ovf  (r_ovf),
    .i_acc      (r_acc),
    .o_hi       (w_fix_hi),
    .o_lo       (w_fix_lo)
  );

  assign w_ovf = (op == OP_DIV) && (a == C_MOST_NEG) && (&b);

  // Multiply: r_acc = {partial sum, remaining multiplier bits}, r_opnd = multiplicand.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {partial remainder, dividend/quotient bits}, r_opnd = divisor.
  // The difference fits WIDTH bits whenever it is kept, since the remainder < divisor.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
  assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && (op == OP_MTHI)) begin
              r_hi <= a;
            end else if (start && (op == OP_MTLO)) begin
              r_lo <= a;
            end else if (start && op_is_iter(op)) begin
              r_is_div <= op_is_div(op);
              r_sign_a <= w_sign_a;
              r_sign_b <= w_sign_b;
              r_zero   <= (b == '0);
              r_ovf    <= w_ovf;
              r_opnd   <= op_is_div(op) ? w_mag_b : w_mag_a;
              r_acc    <= {{WIDTH{1'b0}}, (op_is_div(op) ? w_mag_a : w_mag_b)};
              r_cnt    <= CNT_W'(WIDTH);
              r_state  <= ST_RUN;
            end
          end
          ST_RUN: begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_FIX;
            end
          end
          ST_FIX: begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule : mdu_hilo_unit
`default_nettype wire

// File: tb/tb_mdu_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_hilo_unit
// Brief    : Directed-vector scoreboard bench for mdu_hilo_unit (WIDTH=32).
// Revision : 1.0
// ============================================================================
module tb_mdu_hilo_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mdu_hilo_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb_q[$];

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per done pulse and checks value, timing and busy length.
  int busy_run = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
      end else if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_done_cycle"}, W'(cyc), W'(e.cyc));
          chk({e.name, "_busy_cycles"}, W'(busy_run), W'(W + 1));
          chk({e.name, "_busy_at_done"}, W'(busy), W'(0));
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb_q.push_back('{eh, el, cyc + W + 2, nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_raw(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending%0d expected=pending0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] save_hi;
    logic [W-1:0] save_lo;

    // Reset state
    #2;
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI / MTLO
    issue_raw(OP_MTHI, 32'h12345678, '0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", W'(busy), W'(0));
    issue_raw(OP_MTLO, 32'h9ABCDEF0, '0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_held", hi, 32'h12345678);
    chk("mtlo_busy", W'(busy), W'(0));

    // Multiply signed/unsigned
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3");
    wait_done();
    issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, "multu_fffffffex3");
    wait_done();
    issue(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin");
    wait_done();

    // Divide signed/unsigned
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
    wait_done();
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2");
    wait_done();

    // DIVU with an ignored start while busy
    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7");
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Divide special cases
    issue(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu_5by0");
    wait_done();
    issue(OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_neg5by0");
    wait_done();
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow");
    wait_done();

    // Flush mid-run: no done, HI/LO untouched
    save_hi = hi;
    save_lo = lo;
    issue_raw(OP_MULT, 32'd3, 32'd4);
    chk("flush_busy_before", W'(busy), W'(1));
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", W'(busy), W'(0));
    chk("flush_hi_held", hi, save_hi);
    chk("flush_lo_held", lo, save_lo);
    repeat (40) @(negedge clk);
    chk("flush_hi_late", hi, save_hi);

    // Flush with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op    = OP_MTHI;
    a     = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_hi_held", hi, save_hi);
    chk("flush_start_busy", W'(busy), W'(0));

    // Asynchronous reset in the middle of RUN
    issue_raw(OP_MULT, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_hi", hi, '0);
    chk("areset_lo", lo, '0);
    chk("areset_busy", W'(busy), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7");
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sb_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mdu_hilo_unit
`default_nettype wire
